ysyx_22050078_pcu: RTL and testbench

The PC unit is the fetch front end that sits directly upstream of the instruction-fetch stage. It owns the architectural fetch PC and issues one fetch request at a time over a valid/ready request channel. It captures the returned instruction word and presents it, tagged with its PC, to the decode stage over a valid/ready channel. It also services branch/jump redirects from the execute stage, squashing any in-flight or held instruction.

---
 rtl/ysyx_22050078_pcu.sv | 175 +++++++++++++++++
 tb/tb_ysyx_22050078_pcu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050078_pcu.sv
// ----------------------------------------------------------------------------
// ysyx_22050078_pcu -- PC unit / fetch front end
//
// Owns the architectural fetch PC. Issues one fetch request at a time on a
// valid/ready request channel, captures the returned instruction word and
// holds it, tagged with its PC, for decode on a valid/ready channel. Redirects
// from execute replace the PC and squash any in-flight or held instruction.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   o_req_valid/o_req_pc      fetch request (o_req_pc is the current PC)
//   i_req_ready               fetch request accepted this cycle
//   i_rsp_valid/i_rsp_ins     instruction response (only honoured in WAIT)
//   o_ins_valid/o_ins/o_pc    held instruction and its PC, for decode
//   i_ins_ready               decode consumes the held instruction
//   i_redirect/i_redirect_pc  branch/jump redirect from execute
//   o_misalign                one-cycle pulse after a rejected misaligned
//                             redirect (only with the macro below)
//
// Configuration:
//   YSYX_22050078_PCU_ALIGN_CHECK_EN  when defined, redirects whose target has
//   i_redirect_pc[1:0] != 0 are rejected and flagged on o_misalign.
// ----------------------------------------------------------------------------
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

module ysyx_22050078_pcu #(
  parameter logic [`CPU_WIDTH-1:0] RESET_PC = `CPU_WIDTH'h0000_0000_8000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_req_valid,
  output logic [`CPU_WIDTH-1:0] o_req_pc,
  input  logic                  i_req_ready,
  input  logic                  i_rsp_valid,
  input  logic [`INS_WIDTH-1:0] i_rsp_ins,
  output logic                  o_ins_valid,
  output logic [`INS_WIDTH-1:0] o_ins,
  output logic [`CPU_WIDTH-1:0] o_pc,
  input  logic                  i_ins_ready,
  input  logic                  i_redirect,
  input  logic [`CPU_WIDTH-1:0] i_redirect_pc
`ifdef YSYX_22050078_PCU_ALIGN_CHECK_EN
  ,
  output logic                  o_misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } state_t;

  localparam logic [`CPU_WIDTH-1:0] PC_STEP = `CPU_WIDTH'd4;

  state_t                  state, state_nxt;
  logic [`CPU_WIDTH-1:0]   pc, pc_nxt;
  logic                    drop, drop_nxt;
  logic [`INS_WIDTH-1:0]   ins_q;
  logic [`CPU_WIDTH-1:0]   pc_q;
  logic                    redirect_ok;
  logic                    capture;

  // A redirect that is accepted; a rejected one behaves as if absent.
`ifdef YSYX_22050078_PCU_ALIGN_CHECK_EN
  logic misalign_q;
  assign redirect_ok = i_redirect && (i_redirect_pc[1:0] == 2'b00);
  assign o_misalign  = misalign_q;
`else
  assign redirect_ok = i_redirect;
`endif

  // Word is latched only when WAIT sees a live response that is neither
  // marked stale nor squashed by a redirect in the same cycle.
  assign capture = (state == S_WAIT) && i_rsp_valid && !drop && !redirect_ok;

  // State register plus PC/drop and the decode holding registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      drop  <= 1'b0;
      ins_q <= '0;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
      if (capture) begin
        ins_q <= i_rsp_ins;
        pc_q  <= pc;
      end
    end
  end

`ifdef YSYX_22050078_PCU_ALIGN_CHECK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) misalign_q <= 1'b0;
    else       misalign_q <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
  end
`endif

  // Next-state logic. Redirect outranks every other event in the same cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every target -- no latches.
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    unique case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        if (redirect_ok) pc_nxt = i_redirect_pc;
      end
      S_REQ: begin
        if (redirect_ok) begin
          pc_nxt = i_redirect_pc;
          // The accepted request carried the old PC; its response is stale.
          if (i_req_ready) begin
            state_nxt = S_WAIT;
            drop_nxt  = 1'b1;
          end
        end else if (i_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_ok) begin
          pc_nxt = i_redirect_pc;
          if (i_rsp_valid) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            drop_nxt  = 1'b1;
          end
        end else if (i_rsp_valid) begin
          if (drop) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            state_nxt = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redirect_ok) begin
          pc_nxt    = i_redirect_pc;
          state_nxt = S_REQ;
        end else if (i_ins_ready) begin
          pc_nxt    = pc + PC_STEP;   // wraps modulo 2^CPU_WIDTH
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: handshake valids are pure functions of the state.
  always_comb begin
    o_req_valid = (state == S_REQ);
    o_ins_valid = (state == S_FULL);
  end

  assign o_req_pc = pc;
  assign o_ins    = ins_q;
  assign o_pc     = pc_q;

endmodule

// File: tb/tb_ysyx_22050078_pcu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050078_pcu -- directed self-checking bench for ysyx_22050078_pcu
//
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are written out by hand in each directed step.
// ----------------------------------------------------------------------------
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

module tb_ysyx_22050078_pcu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic                  i_clk;
  logic                  i_rst;
  logic                  o_req_valid;
  logic [`CPU_WIDTH-1:0] o_req_pc;
  logic                  i_req_ready;
  logic                  i_rsp_valid;
  logic [`INS_WIDTH-1:0] i_rsp_ins;
  logic                  o_ins_valid;
  logic [`INS_WIDTH-1:0] o_ins;
  logic [`CPU_WIDTH-1:0] o_pc;
  logic                  i_ins_ready;
  logic                  i_redirect;
  logic [`CPU_WIDTH-1:0] i_redirect_pc;
`ifdef YSYX_22050078_PCU_ALIGN_CHECK_EN
  logic                  o_misalign;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_22050078_pcu #(.RESET_PC(RST_PC)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_req_valid   (o_req_valid),
    .o_req_pc      (o_req_pc),
    .i_req_ready   (i_req_ready),
    .i_rsp_valid   (i_rsp_valid),
    .i_rsp_ins     (i_rsp_ins),
    .o_ins_valid   (o_ins_valid),
    .o_ins         (o_ins),
    .o_pc          (o_pc),
    .i_ins_ready   (i_ins_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc)
`ifdef YSYX_22050078_PCU_ALIGN_CHECK_EN
    ,
    .o_misalign    (o_misalign)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  logic [31:0] ins_tbl [3];

  initial begin
    ins_tbl[0] = 32'h0000_0413;
    ins_tbl[1] = 32'h0010_0493;
    ins_tbl[2] = 32'h00A0_0513;

    i_rst = 1'b1;
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_ins = '0;
    i_ins_ready = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = '0;

    // Reset values.
    step();
    step();
    check("rst_req_valid", 64'(o_req_valid), 64'd0);
    check("rst_ins_valid", 64'(o_ins_valid), 64'd0);
    check("rst_ins",       64'(o_ins),       64'd0);
    check("rst_req_pc",    64'(o_req_pc),    RST_PC);
    check("rst_pc",        64'(o_pc),        RST_PC);

    // Release: IDLE for one cycle, then REQ.
    i_rst = 1'b0;
    i_req_ready = 1'b1;
    i_rsp_valid = 1'b1;
    i_ins_ready = 1'b1;
    check("idle_req_valid", 64'(o_req_valid), 64'd0);
    step();

    // Zero-wait memory: requests every 3 cycles at +0, +4, +8.
    for (int k = 0; k < 3; k++) begin
      check($sformatf("zw%0d_req_valid", k), 64'(o_req_valid), 64'd1);
      check($sformatf("zw%0d_req_pc", k), 64'(o_req_pc), RST_PC + 64'(4 * k));
      i_rsp_ins = ins_tbl[k];
      step();
      check($sformatf("zw%0d_wait_ins_valid", k), 64'(o_ins_valid), 64'd0);
      step();
      check($sformatf("zw%0d_ins_valid", k), 64'(o_ins_valid), 64'd1);
      check($sformatf("zw%0d_ins", k), 64'(o_ins), 64'(ins_tbl[k]));
      check($sformatf("zw%0d_pc", k), 64'(o_pc), RST_PC + 64'(4 * k));
      step();
    end

    // Decode stall in FULL: outputs stable, no request, single +4 on release.
    check("st_req_pc", 64'(o_req_pc), 64'h8000_000C);
    i_ins_ready = 1'b0;
    i_rsp_ins = 32'h00B0_0593;
    step();
    step();
    i_rsp_ins = 32'hFFFF_FFFF;   // ignored outside WAIT
    for (int i = 0; i < 5; i++) begin
      check($sformatf("st%0d_ins_valid", i), 64'(o_ins_valid), 64'd1);
      check($sformatf("st%0d_ins", i), 64'(o_ins), 64'h00B0_0593);
      check($sformatf("st%0d_pc", i), 64'(o_pc), 64'h8000_000C);
      check($sformatf("st%0d_req_valid", i), 64'(o_req_valid), 64'd0);
      step();
    end
    i_ins_ready = 1'b1;
    step();
    check("st_rel_req_valid", 64'(o_req_valid), 64'd1);
    check("st_rel_req_pc", 64'(o_req_pc), 64'h8000_0010);

    // Redirect in the same cycle as request acceptance: stale word dropped.
    i_rsp_valid = 1'b0;
    i_redirect = 1'b1;
    i_redirect_pc = 64'h8000_0100;
    step();
    i_redirect = 1'b0;
    i_rsp_valid = 1'b1;
    i_rsp_ins = 32'hDEAD_BEEF;
    check("rdq_wait_ins_valid", 64'(o_ins_valid), 64'd0);
    step();
    check("rdq_drop_ins_valid", 64'(o_ins_valid), 64'd0);
    check("rdq_req_valid", 64'(o_req_valid), 64'd1);
    check("rdq_req_pc", 64'(o_req_pc), 64'h8000_0100);
    i_rsp_ins = 32'h1111_1111;
    step();
    step();
    check("rdq_ins", 64'(o_ins), 64'h1111_1111);
    check("rdq_pc", 64'(o_pc), 64'h8000_0100);

    // Redirect in FULL with simultaneous consume: no +4 applied.
    i_redirect = 1'b1;
    i_redirect_pc = 64'h8000_0200;
    step();
    i_redirect = 1'b0;
    check("rdf_ins_valid", 64'(o_ins_valid), 64'd0);
    check("rdf_req_pc", 64'(o_req_pc), 64'h8000_0200);

    // Redirect in REQ without acceptance: new target shown, then stable.
    i_req_ready = 1'b0;
    i_redirect = 1'b1;
    i_redirect_pc = 64'h8000_0300;
    step();
    i_redirect = 1'b0;
    check("rdr_req_valid", 64'(o_req_valid), 64'd1);
    check("rdr_req_pc", 64'(o_req_pc), 64'h8000_0300);
    step();
    check("rdr_req_pc_stable", 64'(o_req_pc), 64'h8000_0300);

    // PC wrap: consume at all-ones-minus-3 gives next request at 0.
    i_redirect = 1'b1;
    i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    i_redirect = 1'b0;
    i_req_ready = 1'b1;
    i_rsp_ins = 32'h0000_0013;
    step();
    step();
    check("wrap_pc", 64'(o_pc), 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_ins", 64'(o_ins), 64'h0000_0013);
    step();
    check("wrap_req_pc", 64'(o_req_pc), 64'd0);

    // Redirect in WAIT coinciding with a response: response discarded.
    step();
    i_redirect = 1'b1;
    i_redirect_pc = 64'h8000_0400;
    i_rsp_ins = 32'hBAD0_BAD0;
    step();
    i_redirect = 1'b0;
    i_rsp_valid = 1'b0;
    check("rdw_ins_valid", 64'(o_ins_valid), 64'd0);
    check("rdw_req_valid", 64'(o_req_valid), 64'd1);
    check("rdw_req_pc", 64'(o_req_pc), 64'h8000_0400);

    // Reset in WAIT, late response after release ignored.
    step();
    i_rst = 1'b1;
    #1;
    check("mrst_req_pc", 64'(o_req_pc), RST_PC);
    check("mrst_pc", 64'(o_pc), RST_PC);
    check("mrst_ins", 64'(o_ins), 64'd0);
    step();
    i_rst = 1'b0;
    i_rsp_valid = 1'b1;
    i_rsp_ins = 32'hCAFE_F00D;
    check("mrst_idle_req_valid", 64'(o_req_valid), 64'd0);
    i_req_ready = 1'b0;
    step();
    check("mrst_req_valid", 64'(o_req_valid), 64'd1);
    check("mrst_restart_pc", 64'(o_req_pc), RST_PC);
    step();
    check("mrst_late_ins_valid", 64'(o_ins_valid), 64'd0);

`ifdef YSYX_22050078_PCU_ALIGN_CHECK_EN
    // Misaligned redirect rejected and flagged for one cycle.
    check("mis_idle", 64'(o_misalign), 64'd0);
    i_redirect = 1'b1;
    i_redirect_pc = 64'h8000_0102;
    step();
    i_redirect = 1'b0;
    check("mis_pulse", 64'(o_misalign), 64'd1);
    check("mis_req_pc", 64'(o_req_pc), RST_PC);
    step();
    check("mis_clear", 64'(o_misalign), 64'd0);
    check("mis_req_pc_kept", 64'(o_req_pc), RST_PC);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
